uart_rx_fifo_param: RTL and testbench
=====================================

// Module: uart_rx_fifo_param
// PURPOSE
//  Parametrised UART receive buffer, placed between the RX shift FSM and the APB register block.
//  FIFO mode: received frames are queued in a DEPTH-entry circular buffer.
//  Bypass mode: a single holding register is used instead.
//  Adds full/empty/level status, a programmable threshold flag, sticky overflow and synchronous flush.
// PARAMETERS
//  DATA_W  12  frame width (data+parity+status bits) from RX FSM
//  DEPTH   32  FIFO entries; power of two, >=2
//  PTR_W   $clog2(DEPTH)  derived; pointers are PTR_W+1 bits (extra wrap bit)
// PORTS
//  clk_i       in   1          clock
//  rst_ni      in   1          asynchronous, active-low reset
//  en_i        in   1          receiver enable; 0 = freeze all state, ignore wr/rd
//  fifo_en_i   in   1          1 = FIFO mode, 0 = bypass (single holding register)
//  flush_i     in   1          synchronous flush pulse
//  wr_valid_i  in   1          one-cycle pulse from RX FSM: frame complete
//  wr_data_i   in   DATA_W     received frame
//  rd_req_i    in   1          one-cycle pop request from APB side
//  rx_thresh_i in   PTR_W+1    threshold level; 0 disables thresh_o
//  ovf_clr_i   in   1          clears overflow_o
//  rd_data_o   out  DATA_W     popped frame (registered)
//  rd_valid_o  out  1          pulse: rd_data_o updated this cycle
//  level_o     out  PTR_W+1    entries held (0..DEPTH); bypass: 0/1
//  empty_o     out  1          level_o==0
//  full_o      out  1          level_o==DEPTH (bypass: holding reg occupied)
//  thresh_o    out  1          rx_thresh_i!=0 && level_o>=rx_thresh_i
//  overflow_o  out  1          sticky: a frame was dropped
// BEHAVIOUR
//  Reset (async): wr/rd pointers=0, level_o=0, rd_data_o=0, rd_valid_o=0, overflow_o=0, empty_o=1, full_o=0, thresh_o=0.
//  Storage array is not reset.
//  Priority per cycle: en_i=0 (hold all; rd_valid_o=0) > flush > mode-change > write/read.
//  Flush: pointers=0, level=0, bypass holding reg emptied.
//  Flush leaves rd_data_o and overflow_o unchanged; any wr/rd in the same cycle is ignored.
//  Mode change: a registered copy of fifo_en_i is kept.
//  Any cycle where fifo_en_i differs from that copy performs an implicit flush.
//  FIFO write: wr_valid_i && !full_o -> mem[wr_ptr]<=wr_data_i, wr_ptr++ (wraps mod DEPTH, wrap bit toggles).
//  FIFO read: rd_req_i && !empty_o -> next cycle rd_data_o=mem[rd_ptr], rd_valid_o=1, rd_ptr++.
//  Read latency is 1 clock.
//  Empty/full: empty when pointers are equal.
//  Full when index bits are equal and wrap bits differ; level_o = wr_ptr - rd_ptr.
//  Simultaneous wr+rd, not full/empty: both execute, level unchanged.
//  Simultaneous wr+rd when full: both execute, no overflow, level stays DEPTH.
//  Simultaneous wr+rd when empty: write executes, read ignored (no fall-through); level 0->1, rd_valid_o=0.
//  Write when full without read: frame dropped, pointers hold, overflow_o<=1.
//  Read when empty: ignored, rd_valid_o=0, rd_data_o holds.
//  overflow_o is cleared by ovf_clr_i only.
//  If ovf_clr_i and a new overflow occur in the same cycle, set wins.
//  Bypass: wr_valid_i loads the holding reg and sets occupied.
//  Bypass: rd_req_i while occupied -> rd_data_o=holding, rd_valid_o=1 next cycle, occupied cleared.
//  Bypass: a write while occupied and not read drops the frame and sets overflow_o.
//  Bypass: simultaneous rd+wr while occupied returns the old frame and keeps the new one.
//  Status outputs are combinational from registered state; all update in the cycle after the causing edge.
// TESTING
//  Reset mid-traffic: 5 frames queued, rst_ni low 1 cycle -> level_o=0, empty_o=1, rd_data_o=0, overflow_o=0.
//  Fill/drain: 32 writes 0x001..0x020 -> full_o=1.
//  Fill/drain: 33rd write 0xABC -> dropped, overflow_o=1.
//  Fill/drain: 32 reads return 0x001..0x020 in order, each 1 cycle after rd_req_i; then empty_o=1.
//  Wrap: 20 writes, 20 reads, 20 writes, 20 reads -> data in order across pointer wrap; level_o peaks at 20.
//  Simultaneous: at level 32, wr 0x555 + rd same cycle -> 0x001 out, no overflow.
//  Simultaneous: at level 0, wr+rd -> rd_valid_o=0, level_o=1.
//  Threshold: rx_thresh_i=8 -> thresh_o rises after the 8th write, falls after the next read.
//  Threshold: rx_thresh_i=0 -> thresh_o stays 0.
//  Bypass/mode: fifo_en_i=0, write 0x3C3, rd -> rd_data_o=0x3C3; two writes without read -> overflow_o=1.
//  Bypass/mode: with 3 frames queued in FIFO mode, toggling fifo_en_i -> level_o=0.

Source files
------------

// File: rtl/uart_rx_fifo_param.sv
// uart_rx_fifo_param: UART receive buffer with FIFO/bypass modes, level/threshold status and sticky overflow
module uart_rx_fifo_param #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 32,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              fifo_en_i,
  input  logic              flush_i,
  input  logic              wr_valid_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_req_i,
  input  logic [PTR_W:0]    rx_thresh_i,
  input  logic              ovf_clr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic [PTR_W:0]    level_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              thresh_o,
  output logic              overflow_o
);
  localparam int LW = PTR_W + 1;
  logic [LW-1:0] wr_ptr, rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] hold;
  logic occ, mode_q, clear, act, rd_ok, wr_ok, ovf_set;
  // status is derived from registered state only; bypass reuses the same full/empty rules with capacity 1
  always_comb begin
    level_o   = mode_q ? wr_ptr - rd_ptr : {{PTR_W{1'b0}}, occ};
    empty_o   = level_o == '0;
    full_o    = mode_q ? level_o == LW'(DEPTH) : occ;
    thresh_o  = rx_thresh_i != '0 && level_o >= rx_thresh_i;
    clear     = flush_i || fifo_en_i != mode_q;
    act       = en_i && !clear;
    rd_ok     = act && rd_req_i && !empty_o;
    wr_ok     = act && wr_valid_i && (!full_o || rd_ok);
    ovf_set   = act && wr_valid_i && full_o && !rd_ok;
  end
  // storage array, intentionally not reset
  always_ff @(posedge clk_i) begin
    if (wr_ok && mode_q) mem[wr_ptr[PTR_W-1:0]] <= wr_data_i;
  end
  // pointers, holding register, read port and sticky overflow
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      hold       <= '0;
      occ        <= 1'b0;
      mode_q     <= 1'b1;
      rd_data_o  <= '0;
      rd_valid_o <= 1'b0;
      overflow_o <= 1'b0;
    end else if (en_i) begin
      mode_q     <= fifo_en_i;
      rd_valid_o <= rd_ok;
      wr_ptr     <= clear ? '0 : wr_ptr + LW'(wr_ok && mode_q);
      rd_ptr     <= clear ? '0 : rd_ptr + LW'(rd_ok && mode_q);
      occ        <= !clear && !mode_q && (wr_ok || (occ && !rd_ok));
      if (rd_ok) rd_data_o <= mode_q ? mem[rd_ptr[PTR_W-1:0]] : hold;
      if (wr_ok && !mode_q) hold <= wr_data_i;
      overflow_o <= ovf_set || (overflow_o && !ovf_clr_i);
    end else begin
      rd_valid_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo_param.sv
// tb_uart_rx_fifo_param: directed scenarios plus random traffic checked against a queue-based model
module tb_uart_rx_fifo_param;
  localparam int DATA_W = 12;
  localparam int DEPTH  = 32;
  localparam int PTR_W  = $clog2(DEPTH);
  logic clk_i = 1'b0;
  logic rst_ni, en_i, fifo_en_i, flush_i, wr_valid_i, rd_req_i, ovf_clr_i;
  logic [DATA_W-1:0] wr_data_i, rd_data_o;
  logic [PTR_W:0] rx_thresh_i, level_o;
  logic rd_valid_o, empty_o, full_o, thresh_o, overflow_o;
  int n_run = 0, n_fail = 0;
  logic [DATA_W-1:0] q[$];
  bit m_mode, m_rv, m_ovf;
  logic [DATA_W-1:0] m_rd;
  int peak;

  uart_rx_fifo_param #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .fifo_en_i(fifo_en_i), .flush_i(flush_i),
    .wr_valid_i(wr_valid_i), .wr_data_i(wr_data_i), .rd_req_i(rd_req_i), .rx_thresh_i(rx_thresh_i),
    .ovf_clr_i(ovf_clr_i), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .level_o(level_o),
    .empty_o(empty_o), .full_o(full_o), .thresh_o(thresh_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input int obs, input int exp);
    n_run++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_mode = 1'b1;
    m_rv = 1'b0;
    m_ovf = 1'b0;
    m_rd = '0;
  endfunction

  function automatic void model_step();
    int cap;
    bit full, rok, wok, setv;
    m_rv = 1'b0;
    if (!en_i) return;
    setv = 1'b0;
    if (flush_i || fifo_en_i != m_mode) begin
      q.delete();
      m_mode = fifo_en_i;
    end else begin
      cap  = m_mode ? DEPTH : 1;
      full = q.size() == cap;
      rok  = rd_req_i && q.size() > 0;
      wok  = wr_valid_i && (!full || rok);
      setv = wr_valid_i && full && !rok;
      if (rok) begin
        m_rd = q.pop_front();
        m_rv = 1'b1;
      end
      if (wok) q.push_back(wr_data_i);
    end
    if (setv) m_ovf = 1'b1;
    else if (ovf_clr_i) m_ovf = 1'b0;
  endfunction

  task automatic check_all();
    int lvl;
    lvl = q.size();
    chk("level", int'(level_o), lvl);
    chk("empty", int'(empty_o), int'(lvl == 0));
    chk("full", int'(full_o), int'(lvl == (m_mode ? DEPTH : 1)));
    chk("thresh", int'(thresh_o), int'(rx_thresh_i != 0 && lvl >= int'(rx_thresh_i)));
    chk("overflow", int'(overflow_o), int'(m_ovf));
    chk("rd_valid", int'(rd_valid_o), int'(m_rv));
    chk("rd_data", int'(rd_data_o), int'(m_rd));
  endtask

  task automatic step(input logic w, input logic [DATA_W-1:0] d, input logic r);
    wr_valid_i = w;
    wr_data_i  = d;
    rd_req_i   = r;
    @(posedge clk_i);
    model_step();
    #1;
    check_all();
    if (int'(level_o) > peak) peak = int'(level_o);
    wr_valid_i = 1'b0;
    rd_req_i   = 1'b0;
    flush_i    = 1'b0;
    ovf_clr_i  = 1'b0;
  endtask

  task automatic do_reset();
    wr_valid_i = 1'b0;
    rd_req_i   = 1'b0;
    flush_i    = 1'b0;
    ovf_clr_i  = 1'b0;
    rst_ni     = 1'b0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    model_reset();
    chk("rst_level", int'(level_o), 0);
    chk("rst_empty", int'(empty_o), 1);
    chk("rst_rd_data", int'(rd_data_o), 0);
    chk("rst_overflow", int'(overflow_o), 0);
    check_all();
    step(1'b0, '0, 1'b0);
  endtask

  task automatic do_flush();
    flush_i   = 1'b1;
    ovf_clr_i = 1'b1;
    step(1'b0, '0, 1'b0);
  endtask

  initial begin
    en_i        = 1'b1;
    fifo_en_i   = 1'b1;
    rx_thresh_i = '0;
    wr_data_i   = '0;
    model_reset();
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, DATA_W'(i + 7), 1'b0);
    chk("pre_rst_level", int'(level_o), 5);
    do_reset();
    for (int i = 1; i <= DEPTH; i++) step(1'b1, DATA_W'(i), 1'b0);
    chk("fill_full", int'(full_o), 1);
    step(1'b1, 12'hABC, 1'b0);
    chk("fill_ovf", int'(overflow_o), 1);
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b0, '0, 1'b1);
      chk("drain_valid", int'(rd_valid_o), 1);
      chk("drain_data", int'(rd_data_o), i);
    end
    chk("drain_empty", int'(empty_o), 1);
    do_flush();
    peak = 0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 20; i++) step(1'b1, DATA_W'(100 + 20 * p + i), 1'b0);
      for (int i = 0; i < 20; i++) begin
        step(1'b0, '0, 1'b1);
        chk("wrap_data", int'(rd_data_o), 100 + 20 * p + i);
      end
    end
    chk("wrap_peak", peak, 20);
    do_flush();
    for (int i = 1; i <= DEPTH; i++) step(1'b1, DATA_W'(i), 1'b0);
    step(1'b1, 12'h555, 1'b1);
    chk("sim_full_data", int'(rd_data_o), 1);
    chk("sim_full_ovf", int'(overflow_o), 0);
    chk("sim_full_level", int'(level_o), DEPTH);
    do_flush();
    step(1'b1, 12'h123, 1'b1);
    chk("sim_empty_valid", int'(rd_valid_o), 0);
    chk("sim_empty_level", int'(level_o), 1);
    do_flush();
    rx_thresh_i = 6'd8;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, DATA_W'(i), 1'b0);
      chk("thresh_rise", int'(thresh_o), int'(i == 8));
    end
    step(1'b0, '0, 1'b1);
    chk("thresh_fall", int'(thresh_o), 0);
    rx_thresh_i = '0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, DATA_W'(i), 1'b0);
      chk("thresh_off", int'(thresh_o), 0);
    end
    do_flush();
    fifo_en_i = 1'b0;
    step(1'b0, '0, 1'b0);
    step(1'b1, 12'h3C3, 1'b0);
    step(1'b0, '0, 1'b1);
    chk("byp_data", int'(rd_data_o), 12'h3C3);
    step(1'b1, 12'h111, 1'b0);
    step(1'b1, 12'h222, 1'b0);
    chk("byp_ovf", int'(overflow_o), 1);
    step(1'b1, 12'h333, 1'b1);
    chk("byp_rdwr_data", int'(rd_data_o), 12'h111);
    chk("byp_rdwr_full", int'(full_o), 1);
    fifo_en_i = 1'b1;
    step(1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, DATA_W'(i), 1'b0);
    fifo_en_i = 1'b0;
    step(1'b0, '0, 1'b0);
    chk("mode_flush_level", int'(level_o), 0);
    fifo_en_i = 1'b1;
    step(1'b0, '0, 1'b0);
    for (int i = 0; i < 4000; i++) begin
      int wp;
      wp = ((i / 250) % 2 == 0) ? 70 : 30;
      en_i      = $urandom_range(0, 9) != 0;
      flush_i   = $urandom_range(0, 99) == 0;
      ovf_clr_i = $urandom_range(0, 19) == 0;
      if ($urandom_range(0, 199) == 0) fifo_en_i = ~fifo_en_i;
      if ($urandom_range(0, 63) == 0) rx_thresh_i = (PTR_W + 1)'($urandom_range(0, DEPTH));
      step($urandom_range(0, 99) < wp, DATA_W'($urandom), $urandom_range(0, 99) < 100 - wp);
    end
    en_i = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
